// File: rtl/adc_scan_scheduler_if.sv
// Pin and result bundle for the ADC scan scheduler.
// master: the scheduler; slave: the ADC and datapath side.
interface adc_scan_scheduler_if;
  logic        START;
  logic        CONTINUOUS;
  logic [7:0]  CH_MASK;
  logic        ADC_SCLK;
  logic        ADC_CONVST;
  logic        ADC_SDI;
  logic        ADC_SDO;
  logic [11:0] DATA;
  logic [2:0]  DATA_CH;
  logic        DATA_VALID;
  logic        BUSY;

  modport master (
    input  START,
    input  CONTINUOUS,
    input  CH_MASK,
    input  ADC_SDO,
    output ADC_SCLK,
    output ADC_CONVST,
    output ADC_SDI,
    output DATA,
    output DATA_CH,
    output DATA_VALID,
    output BUSY
  );

  modport slave (
    output START,
    output CONTINUOUS,
    output CH_MASK,
    output ADC_SDO,
    input  ADC_SCLK,
    input  ADC_CONVST,
    input  ADC_SDI,
    input  DATA,
    input  DATA_CH,
    input  DATA_VALID,
    input  BUSY
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin sequencer for an LTC2308-style serial ADC.
// Emits tagged 12-bit results with a one-cycle valid strobe.
module adc_scan_scheduler #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input logic CLOCK_50,
  input logic RESET,
  adc_scan_scheduler_if.master bus
);

  localparam int CMAX =
    (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int CW = (CMAX < 2) ? 1 : $clog2(CMAX);

  typedef enum logic [2:0] {
    IDLE, CONV, GAP, SHIFT, DONE
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]  bit_idx, bit_n;
  logic        half, half_n;
  logic [11:0] shreg, shreg_n;
  logic        sdi, sdi_n;
  logic        sclk, convst, busy, valid;
  logic [11:0] data;
  logic [2:0]  data_ch;
  logic        armed, prime, flush;
  logic [7:0]  mask_q;
  logic [2:0]  cur_ch, prev_ch;
  logic [2:0]  nxt;
  logic        has_nxt;
  logic [5:0]  cfg;
  logic        accept, cont_ok;

  function automatic logic [2:0] first_ch(
    input logic [7:0] m
  );
    logic [2:0] f;
    f = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) f = 3'(i);
    return f;
  endfunction

  assign cfg = {1'b1, cur_ch[0], cur_ch[2],
                cur_ch[1], 1'b1, 1'b0};

  assign accept = (state == IDLE) && !armed &&
                  bus.START && (bus.CH_MASK != '0);
  assign cont_ok = bus.CONTINUOUS &&
                   (bus.CH_MASK != '0);

  // lowest enabled channel above the one just sent
  always_comb begin
    has_nxt = 1'b0;
    nxt     = cur_ch;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) > cur_ch)) begin
        has_nxt = 1'b1;
        nxt     = 3'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    half_n  = half;
    shreg_n = shreg;
    sdi_n   = sdi;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (armed) state_n = CONV;
      end
      CONV: begin
        if (cnt == CW'(CONV_CYCLES - 1)) begin
          state_n = GAP;
          cnt_n   = '0;
          sdi_n   = cfg[5];
        end
      end
      GAP: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          state_n = SHIFT;
          cnt_n   = '0;
          bit_n   = '0;
          half_n  = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n = '0;
          if (!half) begin
            half_n  = 1'b1;
            shreg_n = {shreg[10:0], bus.ADC_SDO};
          end else if (bit_idx == 4'd11) begin
            state_n = DONE;
            sdi_n   = 1'b0;
          end else begin
            half_n = 1'b0;
            bit_n  = bit_idx + 4'd1;
            sdi_n  = (bit_idx < 4'd5) ?
                     cfg[3'd4 - bit_idx[2:0]] : 1'b0;
          end
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = flush ? IDLE : CONV;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      half    <= 1'b0;
      shreg   <= '0;
      sdi     <= 1'b0;
      sclk    <= 1'b0;
      convst  <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      data    <= '0;
      data_ch <= '0;
      armed   <= 1'b0;
      prime   <= 1'b0;
      flush   <= 1'b0;
      mask_q  <= '0;
      cur_ch  <= '0;
      prev_ch <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      half    <= half_n;
      shreg   <= shreg_n;
      sdi     <= sdi_n;
      convst  <= (state_n == CONV);
      sclk    <= (state_n == SHIFT) && half_n;
      busy    <= (state_n != IDLE);
      valid   <= 1'b0;
      if ((state == SHIFT) && (state_n == DONE) &&
          !prime) begin
        valid   <= 1'b1;
        data    <= shreg;
        data_ch <= prev_ch;
      end
      if (accept) begin
        armed  <= 1'b1;
        mask_q <= bus.CH_MASK;
        cur_ch <= first_ch(bus.CH_MASK);
        prime  <= 1'b1;
        flush  <= 1'b0;
      end
      if ((state == IDLE) && armed) armed <= 1'b0;
      // pick the channel the next frame configures
      if (state == DONE) begin
        prime   <= 1'b0;
        prev_ch <= cur_ch;
        if (!flush) begin
          if (has_nxt) begin
            cur_ch <= nxt;
          end else if (cont_ok) begin
            mask_q <= bus.CH_MASK;
            cur_ch <= first_ch(bus.CH_MASK);
          end else begin
            flush  <= 1'b1;
            cur_ch <= first_ch(mask_q);
          end
        end
      end
    end
  end

  assign bus.ADC_SCLK   = sclk;
  assign bus.ADC_CONVST = convst;
  assign bus.ADC_SDI    = sdi;
  assign bus.DATA       = data;
  assign bus.DATA_CH    = data_ch;
  assign bus.DATA_VALID = valid;
  assign bus.BUSY       = busy;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with an ADC model
// and a result scoreboard.
module tb_adc_scan_scheduler;

  logic CLOCK_50 = 1'b0;
  logic RESET;
  always #10 CLOCK_50 = ~CLOCK_50;

  adc_scan_scheduler_if ifc();

  adc_scan_scheduler #(
    .CLK_DIV(2),
    .CONV_CYCLES(80)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .bus(ifc)
  );

  int tests = 0;
  int fails = 0;

  logic [11:0] vals [8];
  logic [11:0] adc_out = '0;
  logic [11:0] adc_sr  = '0;

  // ADC: captures config on SCLK rise, converts the
  // previously configured channel when CONVST rises
  always @(posedge ifc.ADC_SCLK or posedge ifc.ADC_CONVST) begin
    if (ifc.ADC_CONVST)
      adc_out <= vals[{adc_sr[9], adc_sr[8], adc_sr[10]}];
    else begin
      adc_out <= {adc_out[10:0], 1'b0};
      adc_sr  <= {adc_sr[10:0], ifc.ADC_SDI};
    end
  end
  assign ifc.ADC_SDO = adc_out[11];

  logic [14:0] exp_q [$];
  logic [5:0]  sdi_q [$];
  int cyc, frames, strobes, busy_cyc, sclk_rises;
  int conv_run, last_conv_run, last_conv_rise, frame_len;
  int last_strobe, strobe_gap, last_sclk_rise, sclk_per;
  int sdi_bits;
  logic conv_p, sclk_p;
  logic [11:0] sdi_sr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    frames = 0; strobes = 0; busy_cyc = 0;
    sclk_rises = 0; conv_run = 0; last_conv_run = -1;
    last_conv_rise = -1; frame_len = -1;
    last_strobe = -1; strobe_gap = -1;
    last_sclk_rise = -1; sclk_per = -1;
    sdi_bits = 0; sdi_sr = '0;
    conv_p = 1'b0; sclk_p = 1'b0;
    sdi_q.delete();
  endtask

  task automatic sample();
    logic [14:0] e;
    @(negedge CLOCK_50);
    cyc++;
    if (ifc.BUSY) busy_cyc++;
    if (ifc.ADC_CONVST) begin
      if (!conv_p) begin
        frames++;
        if (last_conv_rise >= 0)
          frame_len = cyc - last_conv_rise;
        last_conv_rise = cyc;
        conv_run = 0;
      end
      conv_run++;
    end else if (conv_p) begin
      last_conv_run = conv_run;
    end
    if (ifc.ADC_SCLK && !sclk_p) begin
      sclk_rises++;
      if (last_sclk_rise >= 0)
        sclk_per = cyc - last_sclk_rise;
      last_sclk_rise = cyc;
      sdi_sr = {sdi_sr[10:0], ifc.ADC_SDI};
      sdi_bits++;
      if (sdi_bits == 12) begin
        sdi_q.push_back(sdi_sr[11:6]);
        sdi_bits = 0;
      end
    end
    if (ifc.DATA_VALID) begin
      strobes++;
      if (last_strobe >= 0) strobe_gap = cyc - last_strobe;
      last_strobe = cyc;
      if (exp_q.size() == 0) begin
        chk("sb_strobe_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_ch", ifc.DATA_CH, e[14:12]);
        chk("strobe_data", ifc.DATA, e[11:0]);
      end
    end
    conv_p = ifc.ADC_CONVST;
    sclk_p = ifc.ADC_SCLK;
  endtask

  task automatic pulse_start();
    ifc.START = 1'b1;
    sample();
    ifc.START = 1'b0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_convst"}, ifc.ADC_CONVST, 0);
    chk({pfx, "_sclk"}, ifc.ADC_SCLK, 0);
    chk({pfx, "_sdi"}, ifc.ADC_SDI, 0);
    chk({pfx, "_data"}, ifc.DATA, 0);
    chk({pfx, "_data_ch"}, ifc.DATA_CH, 0);
    chk({pfx, "_valid"}, ifc.DATA_VALID, 0);
    chk({pfx, "_busy"}, ifc.BUSY, 0);
  endtask

  initial begin
    vals = '{12'hA5C, 12'h1B2, 12'h3F1, 12'h4C4,
             12'h5D5, 12'h6E6, 12'h7F7, 12'h808};
    cyc = 0;
    clr();
    RESET = 1'b1;
    ifc.START = 1'b1;
    ifc.CH_MASK = 8'h05;
    ifc.CONTINUOUS = 1'b0;
    repeat (3) sample();
    chk_reset_outs("rst");
    chk("rst_no_frames", frames, 0);
    RESET = 1'b0;
    ifc.START = 1'b0;
    sample();

    // single-shot over channels 0 and 2
    clr();
    exp_q.push_back({3'd0, 12'hA5C});
    exp_q.push_back({3'd2, 12'h3F1});
    pulse_start();
    chk("edge0_busy", ifc.BUSY, 0);
    chk("edge0_convst", ifc.ADC_CONVST, 0);
    sample();
    chk("edge1_busy", ifc.BUSY, 1);
    chk("edge1_convst", ifc.ADC_CONVST, 1);
    repeat (400) sample();
    chk("ss_frames", frames, 3);
    chk("ss_sdi_count", sdi_q.size(), 3);
    chk("ss_sdi0", sdi_q[0], 6'b100010);
    chk("ss_sdi1", sdi_q[1], 6'b100110);
    chk("ss_sdi2", sdi_q[2], 6'b100010);
    chk("ss_strobes", strobes, 2);
    chk("ss_sb_left", exp_q.size(), 0);
    chk("ss_busy_end", ifc.BUSY, 0);
    chk("ss_busy_cycles", busy_cyc, 393);
    chk("conv_high", last_conv_run, 80);
    chk("sclk_period", sclk_per, 4);
    chk("sclk_pulses", sclk_rises, 36);
    chk("frame_len", frame_len, 131);
    chk("strobe_gap", strobe_gap, 131);

    // continuous, stop requested mid second pass
    clr();
    ifc.CH_MASK = 8'hFF;
    ifc.CONTINUOUS = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back({3'(c), vals[c]});
    pulse_start();
    repeat (12 * 131) sample();
    ifc.CONTINUOUS = 1'b0;
    repeat (5 * 131 + 20) sample();
    chk("cont_frames", frames, 17);
    chk("cont_strobes", strobes, 16);
    chk("cont_sb_left", exp_q.size(), 0);
    chk("cont_busy_cycles", busy_cyc, 17 * 131);
    chk("cont_frame_len", frame_len, 131);
    chk("cont_busy_end", ifc.BUSY, 0);

    // empty mask ignored, restart while busy ignored
    clr();
    ifc.CH_MASK = 8'h00;
    pulse_start();
    repeat (20) sample();
    chk("zmask_frames", frames, 0);
    chk("zmask_busy", busy_cyc, 0);
    ifc.CH_MASK = 8'h01;
    exp_q.push_back({3'd0, vals[0]});
    pulse_start();
    repeat (10) sample();
    ifc.CH_MASK = 8'hFF;
    pulse_start();
    repeat (300) sample();
    chk("busy_start_frames", frames, 2);
    chk("busy_start_strobes", strobes, 1);
    chk("busy_start_cycles", busy_cyc, 262);
    chk("busy_start_sb_left", exp_q.size(), 0);

    // reset in the middle of SHIFT bit 6
    clr();
    ifc.CH_MASK = 8'h01;
    pulse_start();
    repeat (107) sample();
    chk("pre_reset_sclk", sclk_rises, 6);
    RESET = 1'b1;
    sample();
    chk_reset_outs("midrst");
    RESET = 1'b0;
    clr();
    exp_q.push_back({3'd0, vals[0]});
    pulse_start();
    repeat (270) sample();
    chk("rerun_frames", frames, 2);
    chk("rerun_strobes", strobes, 1);
    chk("rerun_sb_left", exp_q.size(), 0);
    chk("rerun_busy_end", ifc.BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Sequencing controller for the 8-channel LTC2308-style serial ADC on the board. It drives the ADC's CONVST/SCLK/SDI/SDO pins and round-robins conversions over a programmable channel mask, in single-shot or continuous mode. It returns tagged 12-bit results with a one-cycle valid strobe, so the datapath no longer has to hard-wire CH0.

## Interface
- CLK_DIV, 2: ADC_SCLK half-period in CLOCK_50 cycles. Legal range ≥1. SCLK = 50 MHz / (2·CLK_DIV).
- CONV_CYCLES, 80: CLOCK_50 cycles ADC_CONVST is held high per frame (conversion time). Legal range ≥2.
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  level-sampled each cycle. Begins a scan when the block is idle.
- CONTINUOUS  in  1  1 = repeat passes; 0 = stop at the end of the current pass.
- CH_MASK  in  8  bit n enables channel n.
- ADC_SCLK  out  1  ADC serial clock; idles low.
- ADC_CONVST  out  1  conversion start; high during conversion.
- ADC_SDI  out  1  6-bit config word, MSB first.
- ADC_SDO  in  1  result bits, MSB first.
- DATA  out  12  last result; holds until the next strobe.
- DATA_CH  out  3  channel of DATA.
- DATA_VALID  out  1  one-cycle strobe; DATA and DATA_CH are valid in that cycle.
- BUSY  out  1  high from the cycle after START is accepted until return to IDLE.

## Operation
- States:
  - IDLE: no frame activity.
  - CONV: ADC_CONVST=1 for CONV_CYCLES cycles.
  - GAP: CONVST=0 for CLK_DIV cycles; SDI presents config bit 5.
  - SHIFT: 12 SCLK periods.
  - DONE: 1 cycle.
- Transitions:
  - IDLE→CONV on START with CH_MASK≠0. CH_MASK is latched at this point.
  - DONE→CONV if more frames remain; otherwise DONE→IDLE.
- Config word for channel n: {1, n[0], n[2], n[1], 1, 0}. This selects single-ended, unipolar, no sleep.
- Pipeline: the ADC returns, in frame k, the conversion configured in frame k-1.
  - The first frame after START is a prime frame. Its result is discarded and DATA_VALID stays low in its DONE.
  - The channel tag is the channel sent in the previous frame.
- Channel order: ascending enabled channels, 0→7, within a pass.
- Single-shot: N enabled channels produce N+1 frames. The final frame sends the first enabled channel's config, and its result is never reported. Exactly N strobes are issued.
- Continuous: the frame returning the last channel of pass p sends the first channel of pass p+1, so there is no extra frame between passes.
  - CH_MASK is re-latched at each pass boundary.
  - If the re-latched mask is 0, or CONTINUOUS=0 at the boundary, the block finishes with a single flush frame and then goes to IDLE.
- START while BUSY: ignored. START with CH_MASK=0: ignored; BUSY stays 0.
- RESET: takes priority over everything, including when it coincides with START. A reset mid-frame aborts the frame on the next edge; the next START begins with a fresh prime frame.

## Timing
- Reset values: ADC_CONVST=0, ADC_SCLK=0, ADC_SDI=0, DATA=0, DATA_CH=0, DATA_VALID=0, BUSY=0; FSM in IDLE.
- The START-accept edge is edge 0. CONVST rises and BUSY rises at edge 1.
- SHIFT, bit i (0..11): SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - ADC_SDO is sampled on the edge that drives SCLK 0→1.
  - SDI changes on the edge that drives SCLK 1→0. It carries config bit 5-(i+1) for i<5, then 0.
  - SCLK returns low on entering DONE.
- Frame length: CONV_CYCLES + CLK_DIV + 24·CLK_DIV + 1. With defaults this is 80+2+48+1 = 131 cycles.
- DATA/DATA_CH update on the edge that raises DATA_VALID (the DONE cycle). Strobe spacing is exactly one frame length.
- BUSY falls on the edge leaving the final DONE.

## Test plan
- Reset: assert RESET 3 cycles with START=1 -> all outputs at reset values; no CONVST activity.
- Single-shot, CH_MASK=8'b00000101, SDO model returns 12'hA5C for ch0 and 12'h3F1 for ch2 -> 3 frames; SDI words 100010, 100110, 100010; 2 strobes: (ch0, A5C) then (ch2, 3F1); BUSY low after frame 3.
- Frame timing with defaults -> CONVST high exactly 80 cycles; SCLK period 4 cycles, 12 pulses; frame 131 cycles; strobe spacing 131.
- Continuous, CH_MASK=8'hFF; drop CONTINUOUS in the middle of the second pass -> strobes for ch 0..7, then 0..7 again with no gap frame; then 1 flush frame; IDLE; 16 strobes total.
- START with CH_MASK=0, then START asserted while BUSY -> no frames in the first case, no restart in the second; strobe count unchanged.
- RESET during SHIFT bit 6, then START with CH_MASK=8'h01 -> outputs at reset values on the next edge; the new scan has a prime frame plus 1 strobe (ch0).
